// File: rtl/uart_route_scheduler_if.sv
// uart_route_scheduler_if
//   Groups the byte-source handshakes, the transmitter/VGA launch signals and
//   the status outputs of uart_route_scheduler into one bundle.
//   Sources : kb_*, brd_*, sw_*   valid level + data byte, captured on a rising valid
//   Sinks   : pc_tx_*, brd_tx_*   start pulse, held data byte, busy feedback
//             vga_we / vga_data   write strobe and held data byte
//   Status  : fifo_full {sw,brd,kb}, drop_cnt, timeout_cnt
//   Modports: master = scheduler side, slave = environment (sources, tx, vga).
interface uart_route_scheduler_if;
  logic       kb_valid;
  logic [7:0] kb_data;
  logic       brd_valid;
  logic [7:0] brd_data;
  logic       sw_valid;
  logic [7:0] sw_data;
  logic       pc_tx_en;
  logic [7:0] pc_tx_data;
  logic       pc_tx_busy;
  logic       brd_tx_en;
  logic [7:0] brd_tx_data;
  logic       brd_tx_busy;
  logic       vga_we;
  logic [7:0] vga_data;
  logic [2:0] fifo_full;
  logic [7:0] drop_cnt;
  logic [7:0] timeout_cnt;

  modport master (
    input  kb_valid, kb_data, brd_valid, brd_data, sw_valid, sw_data,
    input  pc_tx_busy, brd_tx_busy,
    output pc_tx_en, pc_tx_data, brd_tx_en, brd_tx_data, vga_we, vga_data,
    output fifo_full, drop_cnt, timeout_cnt
  );

  modport slave (
    output kb_valid, kb_data, brd_valid, brd_data, sw_valid, sw_data,
    output pc_tx_busy, brd_tx_busy,
    input  pc_tx_en, pc_tx_data, brd_tx_en, brd_tx_data, vga_we, vga_data,
    input  fifo_full, drop_cnt, timeout_cnt
  );
endinterface

// File: rtl/uart_route_scheduler.sv
// uart_route_scheduler
//   Byte router between three sources (PC rx = kb, peer board rx = brd,
//   switches = sw) and three sinks (PC tx, board tx, VGA text port).
//   Each source has a DEPTH-entry FIFO fed by a rising edge of its valid level.
//   A round-robin scheduler (kb->brd->sw) pops one byte at a time, waits for
//   its destination transmitters to be idle, launches it with one-cycle
//   en/we pulses, then waits for every launched transmitter to raise and drop
//   busy. A transmitter that never raises busy within ACK_TIMEOUT cycles is
//   abandoned and counted in timeout_cnt.
//   Ports:
//     clk    scheduler clock
//     reset  asynchronous active-high reset
//     bus    uart_route_scheduler_if.master (sources, sinks, status)
//   Routing: kb->{brd_tx,vga}, brd->{pc_tx,vga}, sw->{pc_tx,brd_tx,vga}.
module uart_route_scheduler #(
  parameter int DEPTH       = 4,
  parameter int ACK_TIMEOUT = 16
) (
  input logic                    clk,
  input logic                    reset,
  uart_route_scheduler_if.master bus
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam int TW = $clog2(ACK_TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_ARB       = 3'd1,
    S_WAIT_IDLE = 3'd2,
    S_LAUNCH    = 3'd3,
    S_WAIT_ACK  = 3'd4,
    S_WAIT_DONE = 3'd5
  } state_t;

  // Destination mask layout: bit0 = pc_tx, bit1 = brd_tx, bit2 = vga.
  function automatic logic [2:0] route_mask(input logic [1:0] src);
    logic [2:0] m;
    case (src)
      2'd0:    m = 3'b110;
      2'd1:    m = 3'b101;
      2'd2:    m = 3'b111;
      default: m = 3'b000;
    endcase
    return m;
  endfunction

  function automatic logic [1:0] next_src(input logic [1:0] src);
    logic [1:0] n;
    case (src)
      2'd0:    n = 2'd1;
      2'd1:    n = 2'd2;
      default: n = 2'd0;
    endcase
    return n;
  endfunction

  // First non-empty source searching from ptr in kb->brd->sw order.
  function automatic logic [1:0] rr_pick(input logic [1:0] ptr, input logic [2:0] ne);
    logic [1:0] first;
    logic [1:0] second;
    logic [1:0] third;
    logic [1:0] pick;
    case (ptr)
      2'd1: begin first = 2'd1; second = 2'd2; third = 2'd0; end
      2'd2: begin first = 2'd2; second = 2'd0; third = 2'd1; end
      default: begin first = 2'd0; second = 2'd1; third = 2'd2; end
    endcase
    if (ne[first]) begin
      pick = first;
    end else if (ne[second]) begin
      pick = second;
    end else begin
      pick = third;
    end
    return pick;
  endfunction

  // ---------------------------------------------------------------- state
  logic [2:0]    hist_q;
  logic [7:0]    mem_q    [3][DEPTH];
  logic [AW-1:0] wr_ptr_q [3];
  logic [AW-1:0] rd_ptr_q [3];
  logic [CW-1:0] cnt_q    [3];
  logic [CW-1:0] cnt_d    [3];
  logic [2:0]    full_q;
  logic [7:0]    drop_cnt_q;
  logic [7:0]    drop_cnt_d;

  state_t        state_q;
  logic [1:0]    rr_q;
  logic [2:0]    mask_q;
  logic [7:0]    byte_q;
  logic [TW-1:0] to_q;
  logic [1:0]    seen_q;
  logic [7:0]    timeout_cnt_q;
  logic          pc_tx_en_q;
  logic          brd_tx_en_q;
  logic          vga_we_q;
  logic [7:0]    pc_tx_data_q;
  logic [7:0]    brd_tx_data_q;
  logic [7:0]    vga_data_q;

  // ---------------------------------------------------------------- comb
  logic [2:0] valid_s;
  logic [7:0] data_s [3];
  logic [2:0] push_s;
  logic [2:0] full_s;
  logic [2:0] nonempty_s;
  logic [2:0] accept_s;
  logic [2:0] drop_s;
  logic [2:0] pop_s;
  logic [1:0] win_s;
  logic [2:0] win_mask_s;
  logic [7:0] head_s;
  logic [1:0] busy_s;
  logic [1:0] seen_s;
  logic       go_launch_s;
  logic [2:0] launch_mask_s;
  logic [7:0] launch_byte_s;
  logic [1:0] drop_sum_s;
  logic [8:0] drop_wide_s;

  assign valid_s = {bus.sw_valid, bus.brd_valid, bus.kb_valid};
  assign busy_s  = {bus.brd_tx_busy, bus.pc_tx_busy};

  // Source capture, FIFO bookkeeping and winner selection.
  always_comb begin
    data_s[0] = bus.kb_data;
    data_s[1] = bus.brd_data;
    data_s[2] = bus.sw_data;
    for (int i = 0; i < 3; i++) begin
      nonempty_s[i] = (cnt_q[i] != CW'(0));
      full_s[i]     = (cnt_q[i] == CW'(DEPTH));
      push_s[i]     = valid_s[i] & ~hist_q[i];
    end
    win_s      = rr_pick(rr_q, nonempty_s);
    win_mask_s = route_mask(win_s);
    pop_s      = 3'b000;
    if ((state_q == S_ARB) && (|nonempty_s)) begin
      pop_s[win_s] = 1'b1;
    end else begin
      pop_s = 3'b000;
    end
    case (win_s)
      2'd0:    head_s = mem_q[0][rd_ptr_q[0]];
      2'd1:    head_s = mem_q[1][rd_ptr_q[1]];
      2'd2:    head_s = mem_q[2][rd_ptr_q[2]];
      default: head_s = 8'h00;
    endcase
    // A full FIFO popped in the same cycle still accepts the new byte.
    for (int i = 0; i < 3; i++) begin
      accept_s[i] = push_s[i] & (~full_s[i] | pop_s[i]);
      drop_s[i]   = push_s[i] & full_s[i] & ~pop_s[i];
      case ({accept_s[i], pop_s[i]})
        2'b10:   cnt_d[i] = cnt_q[i] + CW'(1);
        2'b01:   cnt_d[i] = cnt_q[i] - CW'(1);
        default: cnt_d[i] = cnt_q[i];
      endcase
    end
    drop_sum_s  = {1'b0, drop_s[0]} + {1'b0, drop_s[1]} + {1'b0, drop_s[2]};
    drop_wide_s = {1'b0, drop_cnt_q} + {7'b0, drop_sum_s};
    if (drop_wide_s > 9'd255) begin
      drop_cnt_d = 8'hFF;
    end else begin
      drop_cnt_d = drop_wide_s[7:0];
    end
  end

  // Launch decision: from ARB with the freshly popped byte, or from WAIT_IDLE with the latched one.
  always_comb begin
    go_launch_s   = 1'b0;
    launch_mask_s = mask_q;
    launch_byte_s = byte_q;
    seen_s        = seen_q | (busy_s & mask_q[1:0]);
    case (state_q)
      S_ARB: begin
        if (|nonempty_s) begin
          launch_mask_s = win_mask_s;
          launch_byte_s = head_s;
          go_launch_s   = ((win_mask_s[1:0] & busy_s) == 2'b00);
        end else begin
          go_launch_s = 1'b0;
        end
      end
      S_WAIT_IDLE: begin
        go_launch_s = ((mask_q[1:0] & busy_s) == 2'b00);
      end
      default: begin
        go_launch_s = 1'b0;
      end
    endcase
  end

  // Edge history, per-source FIFO storage/pointers, full flags and drop counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hist_q     <= 3'b111;
      full_q     <= 3'b000;
      drop_cnt_q <= 8'h00;
      for (int i = 0; i < 3; i++) begin
        wr_ptr_q[i] <= AW'(0);
        rd_ptr_q[i] <= AW'(0);
        cnt_q[i]    <= CW'(0);
        for (int j = 0; j < DEPTH; j++) begin
          mem_q[i][j] <= 8'h00;
        end
      end
    end else begin
      hist_q     <= valid_s;
      drop_cnt_q <= drop_cnt_d;
      for (int i = 0; i < 3; i++) begin
        if (accept_s[i]) begin
          mem_q[i][wr_ptr_q[i]] <= data_s[i];
          wr_ptr_q[i]           <= wr_ptr_q[i] + AW'(1);
        end
        if (pop_s[i]) begin
          rd_ptr_q[i] <= rd_ptr_q[i] + AW'(1);
        end
        cnt_q[i]  <= cnt_d[i];
        full_q[i] <= (cnt_d[i] == CW'(DEPTH));
      end
    end
  end

  // Scheduler FSM with registered launch strobes, held data bytes and timeout counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= S_IDLE;
      rr_q          <= 2'd0;
      mask_q        <= 3'b000;
      byte_q        <= 8'h00;
      to_q          <= TW'(0);
      seen_q        <= 2'b00;
      timeout_cnt_q <= 8'h00;
      pc_tx_en_q    <= 1'b0;
      brd_tx_en_q   <= 1'b0;
      vga_we_q      <= 1'b0;
      pc_tx_data_q  <= 8'h00;
      brd_tx_data_q <= 8'h00;
      vga_data_q    <= 8'h00;
    end else begin
      // Strobes are high only for the single cycle spent in LAUNCH.
      pc_tx_en_q  <= go_launch_s & launch_mask_s[0];
      brd_tx_en_q <= go_launch_s & launch_mask_s[1];
      vga_we_q    <= go_launch_s & launch_mask_s[2];
      if (go_launch_s && launch_mask_s[0]) pc_tx_data_q  <= launch_byte_s;
      if (go_launch_s && launch_mask_s[1]) brd_tx_data_q <= launch_byte_s;
      if (go_launch_s && launch_mask_s[2]) vga_data_q    <= launch_byte_s;

      case (state_q)
        S_IDLE: begin
          if (|nonempty_s) state_q <= S_ARB;
          else             state_q <= S_IDLE;
        end
        S_ARB: begin
          if (|nonempty_s) begin
            byte_q <= head_s;
            mask_q <= win_mask_s;
            rr_q   <= next_src(win_s);
            if (go_launch_s) state_q <= S_LAUNCH;
            else             state_q <= S_WAIT_IDLE;
          end else begin
            state_q <= S_IDLE;
          end
        end
        S_WAIT_IDLE: begin
          if (go_launch_s) state_q <= S_LAUNCH;
          else             state_q <= S_WAIT_IDLE;
        end
        S_LAUNCH: begin
          to_q   <= TW'(0);
          seen_q <= 2'b00;
          if (mask_q[1:0] == 2'b00) state_q <= S_IDLE;
          else                      state_q <= S_WAIT_ACK;
        end
        S_WAIT_ACK: begin
          seen_q <= seen_s;
          if ((seen_s & mask_q[1:0]) == mask_q[1:0]) begin
            state_q <= S_WAIT_DONE;
          end else if (to_q == TW'(ACK_TIMEOUT - 1)) begin
            if (timeout_cnt_q != 8'hFF) timeout_cnt_q <= timeout_cnt_q + 8'd1;
            state_q <= S_IDLE;
          end else begin
            to_q <= to_q + TW'(1);
          end
        end
        S_WAIT_DONE: begin
          if ((busy_s & mask_q[1:0]) == 2'b00) state_q <= S_IDLE;
          else                                 state_q <= S_WAIT_DONE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.pc_tx_en    = pc_tx_en_q;
  assign bus.pc_tx_data  = pc_tx_data_q;
  assign bus.brd_tx_en   = brd_tx_en_q;
  assign bus.brd_tx_data = brd_tx_data_q;
  assign bus.vga_we      = vga_we_q;
  assign bus.vga_data    = vga_data_q;
  assign bus.fifo_full   = full_q;
  assign bus.drop_cnt    = drop_cnt_q;
  assign bus.timeout_cnt = timeout_cnt_q;

endmodule

// File: tb/tb_uart_route_scheduler.sv
// Directed bench for uart_route_scheduler: per-sink scoreboards are filled
// when a byte is injected and drained when the matching en/we pulse appears.
module tb_uart_route_scheduler;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  uart_route_scheduler_if bus ();

  uart_route_scheduler #(.DEPTH(4), .ACK_TIMEOUT(16)) dut (
    .clk   (clk),
    .reset (rst),
    .bus   (bus)
  );

  int total = 0;
  int bad   = 0;
  int n_pulse = 0;
  logic [7:0] q_pc[$];
  logic [7:0] q_brd[$];
  logic [7:0] q_vga[$];

  // Transmitter models: busy for 'frame' cycles after each start pulse.
  int   frame = 6;
  int   pc_cnt = 0;
  int   brd_cnt = 0;
  int   brd_force = 0;  // 0 model, 1 stuck busy, 2 never busy
  logic pc_busy_m = 1'b0;
  logic brd_busy_m = 1'b0;

  assign bus.pc_tx_busy  = pc_busy_m;
  assign bus.brd_tx_busy = (brd_force == 1) ? 1'b1 : ((brd_force == 2) ? 1'b0 : brd_busy_m);

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (bus.pc_tx_en === 1'b1) pc_cnt = frame;
    else if (pc_cnt > 0) pc_cnt = pc_cnt - 1;
    if (bus.brd_tx_en === 1'b1) brd_cnt = frame;
    else if (brd_cnt > 0) brd_cnt = brd_cnt - 1;
    pc_busy_m  = (pc_cnt > 0);
    brd_busy_m = (brd_cnt > 0);
  end

  // Scoreboard monitor: every pulse must match the oldest expected byte of its sink.
  always @(negedge clk) begin
    logic [7:0] e;
    if (bus.pc_tx_en === 1'b1) begin
      n_pulse++;
      check("pc_expected", 32'(q_pc.size() != 0), 32'd1);
      if (q_pc.size() != 0) begin
        e = q_pc.pop_front();
        check("pc_data", 32'(bus.pc_tx_data), 32'(e));
      end
    end
    if (bus.brd_tx_en === 1'b1) begin
      n_pulse++;
      check("brd_expected", 32'(q_brd.size() != 0), 32'd1);
      if (q_brd.size() != 0) begin
        e = q_brd.pop_front();
        check("brd_data", 32'(bus.brd_tx_data), 32'(e));
      end
    end
    if (bus.vga_we === 1'b1) begin
      n_pulse++;
      check("vga_expected", 32'(q_vga.size() != 0), 32'd1);
      if (q_vga.size() != 0) begin
        e = q_vga.pop_front();
        check("vga_data", 32'(bus.vga_data), 32'(e));
      end
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic expect_route(input int src, input logic [7:0] d);
    if (src == 0) begin q_brd.push_back(d); q_vga.push_back(d); end
    else if (src == 1) begin q_pc.push_back(d); q_vga.push_back(d); end
    else begin q_pc.push_back(d); q_brd.push_back(d); q_vga.push_back(d); end
  endtask

  task automatic send(input int src, input logic [7:0] d, input bit keep);
    @(negedge clk);
    if (src == 0) begin bus.kb_valid = 1'b1; bus.kb_data = d; end
    else if (src == 1) begin bus.brd_valid = 1'b1; bus.brd_data = d; end
    else begin bus.sw_valid = 1'b1; bus.sw_data = d; end
    if (keep) expect_route(src, d);
    @(negedge clk);
    bus.kb_valid = 1'b0; bus.brd_valid = 1'b0; bus.sw_valid = 1'b0;
  endtask

  task automatic wait_drain(input string tag, input int budget);
    int n;
    n = 0;
    while ((q_pc.size() + q_brd.size() + q_vga.size()) != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    check(tag, 32'(q_pc.size() + q_brd.size() + q_vga.size()), 32'd0);
    cycles(10);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int n0;
    int found;
    bus.kb_valid = 1'b1; bus.kb_data = 8'h99;
    bus.brd_valid = 1'b0; bus.brd_data = 8'h00;
    bus.sw_valid = 1'b0; bus.sw_data = 8'h00;

    // 1: reset with kb_valid held high; nothing captured after release.
    #1 rst = 1'b1;
    cycles(3);
    check("rst_strobes", 32'({bus.pc_tx_en, bus.brd_tx_en, bus.vga_we}), 32'd0);
    check("rst_data", 32'({bus.pc_tx_data, bus.brd_tx_data, bus.vga_data}), 32'd0);
    check("rst_status", 32'({bus.fifo_full, bus.drop_cnt, bus.timeout_cnt}), 32'd0);
    rst = 1'b0;
    cycles(10);
    check("t1_full", 32'(bus.fifo_full), 32'd0);
    check("t1_no_pulse", 32'(n_pulse), 32'd0);
    bus.kb_valid = 1'b0;
    cycles(4);
    check("t1_no_pulse_fall", 32'(n_pulse), 32'd0);

    // 3: simultaneous arrivals with the pointer at kb -> 11, 22, 33.
    @(negedge clk);
    bus.kb_valid = 1'b1;  bus.kb_data = 8'h11;
    bus.brd_valid = 1'b1; bus.brd_data = 8'h22;
    bus.sw_valid = 1'b1;  bus.sw_data = 8'h33;
    expect_route(0, 8'h11); expect_route(1, 8'h22); expect_route(2, 8'h33);
    @(negedge clk);
    bus.kb_valid = 1'b0; bus.brd_valid = 1'b0; bus.sw_valid = 1'b0;
    wait_drain("t3_drain", 150);
    check("t3_pulses", 32'(n_pulse), 32'd7);

    // 2: latency of a single kb byte.
    @(negedge clk);
    bus.kb_valid = 1'b1; bus.kb_data = 8'h41;
    expect_route(0, 8'h41);
    @(posedge clk);                // edge k: capture
    @(posedge clk); #1;            // edge k+1
    check("t2_k1_strobes", 32'({bus.pc_tx_en, bus.brd_tx_en, bus.vga_we}), 32'd0);
    bus.kb_valid = 1'b0;
    @(posedge clk); #1;            // edge k+2
    check("t2_k2_strobes", 32'({bus.pc_tx_en, bus.brd_tx_en, bus.vga_we}), 32'b011);
    check("t2_k2_brd_data", 32'(bus.brd_tx_data), 32'h41);
    check("t2_k2_vga_data", 32'(bus.vga_data), 32'h41);
    @(posedge clk); #1;            // edge k+3
    check("t2_k3_strobes", 32'({bus.pc_tx_en, bus.brd_tx_en, bus.vga_we}), 32'd0);
    wait_drain("t2_drain", 60);

    // 4: board tx stuck busy; B0 waits in the scheduler, B1..B4 fill the FIFO, B5 is dropped.
    brd_force = 1;
    n0 = n_pulse;
    for (int i = 0; i < 6; i++) send(0, 8'hB0 + 8'(i), (i < 5));
    cycles(2);
    check("t4_full", 32'(bus.fifo_full), 32'b001);
    check("t4_drop", 32'(bus.drop_cnt), 32'd1);
    cycles(186);
    check("t4_held", 32'(n_pulse), 32'(n0));
    brd_force = 0;
    wait_drain("t4_drain", 200);
    check("t4_full_after", 32'(bus.fifo_full), 32'd0);
    check("t4_drop_after", 32'(bus.drop_cnt), 32'd1);

    // 5: board tx never acknowledges -> timeout, then the next byte is served.
    brd_force = 2;
    send(0, 8'h55, 1'b1);
    found = 0;
    for (int i = 0; i < 20 && found == 0; i++) begin
      if (bus.brd_tx_en === 1'b1) found = 1;
      else @(negedge clk);
    end
    check("t5_launch_seen", 32'(found), 32'd1);
    cycles(8);
    check("t5_before_timeout", 32'(bus.timeout_cnt), 32'd0);
    cycles(12);
    check("t5_timeout", 32'(bus.timeout_cnt), 32'd1);
    brd_force = 0;
    cycles(8);
    send(0, 8'h66, 1'b1);
    wait_drain("t5_next_served", 60);
    check("t5_timeout_kept", 32'(bus.timeout_cnt), 32'd1);

    // 6: reset during WAIT_DONE with two bytes queued.
    frame = 20;
    send(0, 8'hC1, 1'b1);
    send(0, 8'hC2, 1'b0);
    send(0, 8'hC3, 1'b0);
    cycles(2);
    check("t6_first_launched", 32'(q_brd.size() + q_vga.size()), 32'd0);
    n0 = n_pulse;
    rst = 1'b1;
    #1;
    check("t6_rst_strobes", 32'({bus.pc_tx_en, bus.brd_tx_en, bus.vga_we}), 32'd0);
    check("t6_rst_data", 32'({bus.pc_tx_data, bus.brd_tx_data, bus.vga_data}), 32'd0);
    check("t6_rst_status", 32'({bus.fifo_full, bus.drop_cnt, bus.timeout_cnt}), 32'd0);
    cycles(2);
    rst = 1'b0;
    cycles(40);
    check("t6_nothing_launched", 32'(n_pulse), 32'(n0));
    check("final_queues", 32'(q_pc.size() + q_brd.size() + q_vga.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
